// File: rtl/mp5_pkg.sv
// mp5_pkg: types and constants shared by the mp5 pipeline stages.
//   MP5_NUM_PIPELINES / MP5_FIFO_SIZE : default pipeline count and per-stage FIFO depth.
//   Packet    : packet travelling through a stage (phantom flag, target pipeline, id, payload).
//   MapEntry  : one row of the phantom address map (valid, id, slot, FIFO, age).
//   sat_add16 : 16-bit add that sticks at 16'hFFFF.
package mp5_pkg;

  localparam int MP5_NUM_PIPELINES = 4;
  localparam int MP5_FIFO_SIZE     = 8;
  localparam int MP5_PIPE_W        = $clog2(MP5_NUM_PIPELINES);
  localparam int MP5_ADDR_W        = $clog2(MP5_FIFO_SIZE);

  typedef struct packed {
    logic                  is_phantom;
    logic [MP5_PIPE_W-1:0] pipeline;
    logic [15:0]           id;
    logic [31:0]           payload;
  } Packet;

  typedef struct packed {
    logic                  valid;
    logic [15:0]           id;
    logic [MP5_ADDR_W-1:0] addr;
    logic [MP5_PIPE_W-1:0] fifo_id;
    logic [7:0]            age;
  } MapEntry;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/mp5_prio_enc.sv
// mp5_prio_enc: lowest-index-first priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : at least one bit of req_i is set
module mp5_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mp5_phantom_map.sv
// mp5_phantom_map: remembers where phantom packets sit in the stage FIFOs so
// the matching real packet can overwrite the phantom slot instead of queueing.
//   clk, rst (async, active low)
//   rec_valid/rec_id/rec_addr/rec_fifo_id : record a phantom pushed by the stage
//   pkt_valid/pkt_in                      : arriving packet
//   push_out/insert_out/addr_out/fifo_id_out/pkt_out : registered command to the stage
//   occupancy : live count of valid entries
//   drop_cnt  : records lost to a full map (saturating)
//   stale_cnt : entries evicted by age (saturating)
// Both input channels are valid-only: there is no back-pressure, an asserted
// valid is consumed on the rising edge it is sampled at.
module mp5_phantom_map
  import mp5_pkg::*;
#(
  parameter int NUM_PIPELINES = MP5_NUM_PIPELINES,
  parameter int FIFO_SIZE     = MP5_FIFO_SIZE,
  parameter int MAP_DEPTH     = 16,
  parameter int TIMEOUT       = 200
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rec_valid,
  input  logic [15:0]                      rec_id,
  input  logic [$clog2(FIFO_SIZE)-1:0]     rec_addr,
  input  logic [$clog2(NUM_PIPELINES)-1:0] rec_fifo_id,
  input  logic                             pkt_valid,
  input  Packet                            pkt_in,
  output logic                             push_out,
  output logic                             insert_out,
  output logic [$clog2(FIFO_SIZE)-1:0]     addr_out,
  output logic [$clog2(NUM_PIPELINES)-1:0] fifo_id_out,
  output Packet                            pkt_out,
  output logic [$clog2(MAP_DEPTH):0]       occupancy,
  output logic [15:0]                      drop_cnt,
  output logic [15:0]                      stale_cnt
);

  localparam int ADDR_W = $clog2(FIFO_SIZE);
  localparam int PIPE_W = $clog2(NUM_PIPELINES);
  localparam int IDX_W  = $clog2(MAP_DEPTH);
  localparam int OCC_W  = IDX_W + 1;

  MapEntry entries_q [MAP_DEPTH];
  MapEntry entries_d [MAP_DEPTH];

  logic [15:0]       drop_q, drop_d, stale_q, stale_d;
  logic              push_q, push_d, insert_q, insert_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIPE_W-1:0] fifo_q, fifo_d;
  Packet             pkt_q, pkt_d;

  logic [MAP_DEPTH-1:0] rec_hit_vec, lookup_vec, free_vec;
  logic [IDX_W-1:0]     free_idx, match_idx;
  logic                 free_found, match_found, rec_hit_any, alloc, drop;
  logic [OCC_W-1:0]     occ_cnt, n_stale;

  // All match/free vectors are built from the registered map only, so a
  // record landing this cycle is invisible to this cycle's lookup.
  always_comb begin
    for (int i = 0; i < MAP_DEPTH; i++) begin
      rec_hit_vec[i] = rec_valid && entries_q[i].valid && (entries_q[i].id == rec_id);
      lookup_vec[i]  = pkt_valid && !pkt_in.is_phantom && entries_q[i].valid &&
                       (entries_q[i].id == pkt_in.id);
      free_vec[i]    = !entries_q[i].valid;
    end
  end

  mp5_prio_enc #(.WIDTH(MAP_DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .req_i  (free_vec),
    .idx_o  (free_idx),
    .found_o(free_found)
  );

  // Ids are unique in the map (records refresh rather than duplicate), so
  // this only ever sees zero or one request.
  mp5_prio_enc #(.WIDTH(MAP_DEPTH), .IDX_W(IDX_W)) u_match_enc (
    .req_i  (lookup_vec),
    .idx_o  (match_idx),
    .found_o(match_found)
  );

  assign rec_hit_any = |rec_hit_vec;
  assign alloc       = rec_valid && !rec_hit_any && free_found;
  assign drop        = rec_valid && !rec_hit_any && !free_found;

  // Per-entry update. A record writing an entry takes precedence over the
  // lookup consuming it or the age-out: the new phantom must not be lost.
  always_comb begin
    n_stale = '0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].age = entries_q[i].age + 8'd1;
      end
      if (rec_hit_vec[i] || (alloc && (free_idx == IDX_W'(i)))) begin
        entries_d[i].valid   = 1'b1;
        entries_d[i].id      = rec_id;
        entries_d[i].addr    = rec_addr;
        entries_d[i].fifo_id = rec_fifo_id;
        entries_d[i].age     = 8'd0;
      end else if (lookup_vec[i]) begin
        entries_d[i] = '0;
      end else if (entries_q[i].valid && (entries_q[i].age == 8'(TIMEOUT))) begin
        entries_d[i] = '0;
        n_stale      = n_stale + OCC_W'(1);
      end
    end
  end

  always_comb begin
    drop_d  = drop ? sat_add16(drop_q, 16'd1) : drop_q;
    stale_d = sat_add16(stale_q, 16'(n_stale));
  end

  // Stage command for the arriving packet, presented one cycle later.
  always_comb begin
    push_d   = 1'b0;
    insert_d = 1'b0;
    addr_d   = '0;
    fifo_d   = '0;
    pkt_d    = '0;
    if (pkt_valid) begin
      pkt_d = pkt_in;
      if (!pkt_in.is_phantom && match_found) begin
        insert_d = 1'b1;
        addr_d   = entries_q[match_idx].addr;
        fifo_d   = entries_q[match_idx].fifo_id;
      end else begin
        push_d = 1'b1;
        fifo_d = pkt_in.pipeline;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAP_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      drop_q   <= '0;
      stale_q  <= '0;
      push_q   <= 1'b0;
      insert_q <= 1'b0;
      addr_q   <= '0;
      fifo_q   <= '0;
      pkt_q    <= '0;
    end else begin
      for (int i = 0; i < MAP_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      drop_q   <= drop_d;
      stale_q  <= stale_d;
      push_q   <= push_d;
      insert_q <= insert_d;
      addr_q   <= addr_d;
      fifo_q   <= fifo_d;
      pkt_q    <= pkt_d;
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < MAP_DEPTH; i++) begin
      if (entries_q[i].valid) begin
        occ_cnt = occ_cnt + OCC_W'(1);
      end
    end
  end

  assign push_out    = push_q;
  assign insert_out  = insert_q;
  assign addr_out    = addr_q;
  assign fifo_id_out = fifo_q;
  assign pkt_out     = pkt_q;
  assign occupancy   = occ_cnt;
  assign drop_cnt    = drop_q;
  assign stale_cnt   = stale_q;

endmodule
